// File: rtl/bram_read_arbiter.sv
// bram_read_arbiter
// Two-requester read arbiter in front of one shared BRAM read port.
// The grant is combinational, so an address is accepted in the same cycle
// as its request. The last-granted requester keeps priority until it has
// taken MAX_BURST consecutive reads while the other requester is waiting.
// A small tag pipeline (valid + requester ID) follows each read through the
// BRAM latency and sends bram_dout back to the requester that issued it.
//
// Build option: define BRAM_DOUT_REG_EN when the BRAM output register is
// enabled. Read latency is then 2 cycles instead of 1, and the tag pipeline
// is 2 deep. Arbitration is the same in both builds.

module bram_read_arbiter #(
  parameter int ADDR_W    = 20,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] bram_addr,
  output logic              bram_en,
  input  logic [DATA_W-1:0] bram_dout
);

`ifdef BRAM_DOUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  // MAX_BURST is limited to 1..255, so an 8-bit counter always holds it.
  localparam logic [7:0] MAX_CNT = 8'(MAX_BURST);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] burst_cnt_q, burst_cnt_d;
  logic       grant0, grant1;

  // Tag pipeline: stage 0 captures the read issued at this edge.
  // Stage LAT-1 lines up with bram_dout.
  logic       tag_vld_q [LAT];
  logic       tag_id_q  [LAT];

  // Holds the arbitration state and the consecutive-grant counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      burst_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  // Picks this cycle's grant and the next owner / burst count.
  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    grant0      = 1'b0;
    grant1      = 1'b0;
    // Reset is asynchronous, so grants are also blocked while it is held.
    if (reset) begin
      case (state_q)
        IDLE: begin
          if (req0) begin
            grant0      = 1'b1;
            state_d     = OWN0;
            burst_cnt_d = 8'd1;
          end else if (req1) begin
            grant1      = 1'b1;
            state_d     = OWN1;
            burst_cnt_d = 8'd1;
          end
        end
        OWN0: begin
          // The owner keeps the port unless the other side waits and the
          // owner has used up its burst.
          if (req0 && (!req1 || burst_cnt_q < MAX_CNT)) begin
            grant0      = 1'b1;
            burst_cnt_d = (burst_cnt_q < MAX_CNT) ? burst_cnt_q + 8'd1 : MAX_CNT;
          end else if (req1) begin
            grant1      = 1'b1;
            state_d     = OWN1;
            burst_cnt_d = 8'd1;
          end else begin
            state_d     = IDLE;
            burst_cnt_d = 8'd0;
          end
        end
        OWN1: begin
          if (req1 && (!req0 || burst_cnt_q < MAX_CNT)) begin
            grant1      = 1'b1;
            burst_cnt_d = (burst_cnt_q < MAX_CNT) ? burst_cnt_q + 8'd1 : MAX_CNT;
          end else if (req0) begin
            grant0      = 1'b1;
            state_d     = OWN0;
            burst_cnt_d = 8'd1;
          end else begin
            state_d     = IDLE;
            burst_cnt_d = 8'd0;
          end
        end
        default: begin
          state_d     = IDLE;
          burst_cnt_d = 8'd0;
        end
      endcase
    end
  end

  // Moves each issued read's tag down the pipeline. Reset drops reads in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LAT; i++) begin
        tag_vld_q[i] <= 1'b0;
        tag_id_q[i]  <= 1'b0;
      end
    end else begin
      tag_vld_q[0] <= grant0 | grant1;
      tag_id_q[0]  <= grant1;
      for (int i = 1; i < LAT; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_id_q[i]  <= tag_id_q[i-1];
      end
    end
  end

  // Drives the BRAM port and returns read data to the requester that issued it.
  always_comb begin
    gnt0      = grant0;
    gnt1      = grant1;
    bram_en   = grant0 | grant1;
    bram_addr = grant0 ? addr0 : (grant1 ? addr1 : '0);
    rvalid0   = tag_vld_q[LAT-1] & ~tag_id_q[LAT-1];
    rvalid1   = tag_vld_q[LAT-1] &  tag_id_q[LAT-1];
    rdata0    = rvalid0 ? bram_dout : '0;
    rdata1    = rvalid1 ? bram_dout : '0;
  end

endmodule

// File: tb/tb_bram_read_arbiter.sv
// Self-checking bench for bram_read_arbiter.
// A behavioural model recomputes grants and read returns every cycle.
// Directed phases pin the model with hand-computed values.

module tb_bram_read_arbiter;

`ifdef BRAM_DOUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int MAXB = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1;
  logic [19:0] addr0, addr1;
  logic        gnt0, gnt1, rvalid0, rvalid1, bram_en;
  logic [31:0] rdata0, rdata1, bram_dout;
  logic [19:0] bram_addr;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  bram_read_arbiter #(.ADDR_W(20), .DATA_W(32), .MAX_BURST(MAXB)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .bram_addr(bram_addr), .bram_en(bram_en), .bram_dout(bram_dout)
  );

  // BRAM contents: one fixed word plus a simple hash of the address.
  function automatic logic [31:0] word(input logic [19:0] a);
    if (a == 20'h00010) return 32'hDEADBEEF;
    return {a[11:0], a} ^ 32'hA5C30F1E;
  endfunction

  // BRAM model: registered read, plus an optional output register.
  logic [31:0] mem_q1, mem_q2;
  always @(posedge clk) begin
    if (bram_en) mem_q1 <= word(bram_addr);
    mem_q2 <= mem_q1;
  end
`ifdef BRAM_DOUT_REG_EN
  assign bram_dout = mem_q2;
`else
  assign bram_dout = mem_q1;
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model.
  // m_last is the last winner (-1 = none), m_run counts its consecutive grants.
  // pend holds expected read returns in order.
  typedef struct {
    int          due;
    bit          id;
    logic [31:0] data;
  } rd_t;
  rd_t pend[$];
  int  m_last = -1;
  int  m_run  = 0;

  always @(negedge clk) begin
    int          win;
    bit          e_rv0, e_rv1;
    logic [31:0] e_d0, e_d1;
    rd_t         r;
    if (!reset) begin
      m_last = -1;
      m_run  = 0;
      pend.delete();
      chk("reset_outputs",
          {56'd0, gnt0, gnt1, bram_en, rvalid0, rvalid1,
           |bram_addr, |rdata0, |rdata1}, 64'd0);
    end else begin
      e_rv0 = 0; e_rv1 = 0; e_d0 = 0; e_d1 = 0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        r = pend.pop_front();
        if (r.id) begin e_rv1 = 1; e_d1 = r.data; end
        else      begin e_rv0 = 1; e_d0 = r.data; end
      end
      if (req0 && req1) begin
        if (m_last < 0)          win = 0;
        else if (m_run < MAXB)   win = m_last;
        else                     win = 1 - m_last;
      end else if (req0) win = 0;
      else if (req1)     win = 1;
      else               win = -1;

      chk("gnt0", gnt0, win == 0);
      chk("gnt1", gnt1, win == 1);
      chk("bram_en", bram_en, win >= 0);
      chk("bram_addr", bram_addr, win == 0 ? addr0 : (win == 1 ? addr1 : 20'd0));
      chk("rvalid0", rvalid0, e_rv0);
      chk("rvalid1", rvalid1, e_rv1);
      chk("rdata0", rdata0, e_d0);
      chk("rdata1", rdata1, e_d1);

      if (win >= 0) begin
        r.due  = cyc + LAT;
        r.id   = (win == 1);
        r.data = word(win == 0 ? addr0 : addr1);
        pend.push_back(r);
      end
      if (win < 0)            begin m_last = -1; m_run = 0; end
      else if (win == m_last) m_run = (m_run < MAXB) ? m_run + 1 : MAXB;
      else                    begin m_last = win; m_run = 1; end
    end
  end

  initial begin
    int          lat, n, bad, c0, c1;
    bit          got;
    int          seq[40];
    bit          got_id[10];
    logic [31:0] got_d[10];

    reset = 1'b0; req0 = 0; req1 = 0; addr0 = '0; addr1 = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // Single read from requester 0: same-cycle grant, known data, measured latency.
    req0 = 1; addr0 = 20'h00010;
    @(negedge clk);
    chk("dir_gnt0", gnt0, 1);
    chk("dir_addr", bram_addr, 20'h00010);
    @(posedge clk); #1 req0 = 0;
    lat = 0; got = 0;
    while (!got && lat < 6) begin
      @(negedge clk);
      lat++;
      if (rvalid0) got = 1;
    end
    chk("dir_latency", lat, LAT);
    chk("dir_rdata0", rdata0, 32'hDEADBEEF);
    chk("dir_rvalid1", rvalid1, 0);
    $display("read req0 addr=00010 data=%08h latency=%0d", rdata0, lat);
    repeat (3) @(posedge clk);
    #1;

    // Both requesters held for 40 cycles, starting from idle.
    req0 = 1; req1 = 1; addr0 = 20'h00100; addr1 = 20'h00200;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      seq[k] = gnt0 ? 0 : (gnt1 ? 1 : -1);
      @(posedge clk); #1;
      addr0 = 20'h00100 + 20'(k); addr1 = 20'h00200 + 20'(k);
    end
    req0 = 0; req1 = 0;
    bad = 0; c0 = 0; c1 = 0;
    for (int k = 0; k < 40; k++) begin
      if (seq[k] != ((k < 16) ? 0 : (k < 32) ? 1 : 0)) bad++;
      if (seq[k] == 0) c0++;
      if (seq[k] == 1) c1++;
    end
    chk("burst_seq_mismatches", bad, 0);
    chk("burst_cnt0", c0, 24);
    chk("burst_cnt1", c1, 16);
    $display("burst grants: req0=%0d req1=%0d", c0, c1);
    repeat (4) @(posedge clk);
    #1;

    // Requesters alternate every cycle on addresses 0..9.
    n = 0;
    for (int k = 0; k < 14; k++) begin
      if (k < 10) begin
        req0 = (k % 2 == 0); req1 = (k % 2 == 1);
        addr0 = 20'(k); addr1 = 20'(k);
      end else begin
        req0 = 0; req1 = 0;
      end
      @(negedge clk);
      if (rvalid0 || rvalid1) begin
        if (n < 10) begin
          got_id[n] = rvalid1;
          got_d[n]  = rvalid1 ? rdata1 : rdata0;
        end
        n++;
      end
      @(posedge clk); #1;
    end
    chk("alt_count", n, 10);
    for (int k = 0; k < 10 && k < n; k++) begin
      chk("alt_id", got_id[k], k % 2);
      chk("alt_data", got_d[k], word(20'(k)));
      $display("read req%0d addr=%0d data=%08h", got_id[k], k, got_d[k]);
    end
    repeat (2) @(posedge clk);
    #1;

    // Reset asserted right after a grant: that read must not come back.
    req0 = 1; addr0 = 20'h00033;
    @(negedge clk);
    chk("rst_pre_gnt0", gnt0, 1);
    @(posedge clk); #1 reset = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("rst_rvalid0", rvalid0, 0);
      chk("rst_gnt0", gnt0, 0);
    end
    @(posedge clk); #1 reset = 1'b1; req0 = 0;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_quiet", rvalid0, 0);
    end
    @(posedge clk); #1 req0 = 1; addr0 = 20'h00044;
    @(negedge clk);
    chk("post_rst_gnt0", gnt0, 1);
    @(posedge clk); #1 req0 = 0;
    $display("reset during read: in-flight read dropped, grants resumed");

    // Random traffic with occasional resets; the model checks every cycle.
    for (int k = 0; k < 3000; k++) begin
      if (!(req0 && $urandom_range(0, 3) != 0)) addr0 = 20'($urandom);
      if (!(req1 && $urandom_range(0, 3) != 0)) addr1 = 20'($urandom);
      req0 = ($urandom_range(0, 9) < 7);
      req1 = ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 299) == 0) begin
        reset = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1 reset = 1'b1;
      end
      @(posedge clk); #1;
    end
    req0 = 0; req1 = 0;
    repeat (4) @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
